paddle_mover: RTL and testbench
===============================

PADDLE_MOVER -- requirements
Module: paddle_mover

Interface
REQ-001 SHALL have parameter HRES, default 1280: horizontal screen resolution in pixels.
REQ-002 SHALL have parameter VRES, default 720: vertical screen resolution in pixels.
REQ-003 SHALL have parameters PADDLE_W, default 200, and PADDLE_H, default 20: paddle size in pixels.
REQ-004 SHALL have parameter AXIS, default 0: 0 means the paddle moves horizontally; 1 means it moves vertically.
REQ-005 SHALL have parameter EDGE, default 700: fixed top (AXIS=0) or left (AXIS=1) coordinate on the cross axis.
REQ-006 SHALL have parameters SPEED_MIN, default 1, and SPEED_MAX, default 8: step size limits in pixels per frame.
REQ-007 SHALL have parameter ACCEL_FRAMES, default 4: consecutive moving frames per speed increment.
REQ-008 SHALL have parameter COLOR, default 24'hEFE62E: RGB fill colour.
REQ-009 SHALL have port pixel_clk, input, 1 bit: the single clock.
REQ-010 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-011 SHALL have port fsync, input, 1 bit: one-cycle frame-start pulse.
REQ-012 SHALL have ports hpos and vpos, inputs, signed 12 bits each: current scan coordinate.
REQ-013 SHALL have ports inc and dec, inputs, 1 bit each: asynchronous buttons that request movement toward higher or lower coordinates.
REQ-014 SHALL have port pos, output, 12 bits: leading (left or top) coordinate of the paddle on the move axis.
REQ-015 SHALL have ports at_min and at_max, outputs, 1 bit each: paddle is at a clamp limit.
REQ-016 SHALL have ports pixel[0:2], output, 8 bits each, and active, output, 1 bit: pixel[2]=R, pixel[1]=G, pixel[0]=B.

Function
REQ-017 SHALL define RES as HRES when AXIS=0 and VRES when AXIS=1, LEN as PADDLE_W when AXIS=0 and PADDLE_H when AXIS=1, and LIMIT as RES-LEN.
REQ-018 SHALL pass inc and dec each through a 2-flop synchroniser.
REQ-019 While a frame is in progress (fsync=0) and no request is latched, SHALL latch INC when synced inc=1 and dec=0, latch DEC when dec=1 and inc=0, and latch nothing when both or neither are high; a latched request SHALL hold until the next fsync.
REQ-020 On fsync, SHALL load the direction state with the latched request (IDLE if none) and clear the latch in the same cycle.
REQ-021 Direction state SHALL be one of IDLE, INC, DEC; a press seen in frame N SHALL first move the paddle at the fsync that ends frame N+1.
REQ-022 On fsync with state INC, SHALL set pos to min(pos+speed, LIMIT); with state DEC, SHALL set pos to max(pos-speed, 0); arithmetic SHALL be at least 13 bits signed so the result cannot wrap.
REQ-023 On fsync with state IDLE, or with state opposite to the previous moving direction, SHALL set speed to SPEED_MIN and hold_cnt to 0.
REQ-024 On a moving fsync, SHALL increment hold_cnt after the move; when hold_cnt reaches ACCEL_FRAMES it SHALL reset to 0 and speed SHALL increase by 1, saturating at SPEED_MAX; the new speed SHALL apply from the next move onward.
REQ-025 SHALL assert at_min = (pos == 0) and at_max = (pos == LIMIT), both registered alongside pos.
REQ-026 SHALL compute active combinationally, high exactly when the scan position lies inside the paddle rectangle on both axes with inclusive bounds [pos, pos+LEN-1] on the move axis and [EDGE, EDGE+cross_size-1] on the cross axis; negative hpos or vpos SHALL never be active.
REQ-027 SHALL drive pixel to the COLOR bytes when active=1 and to 0 otherwise.

Reset
REQ-028 While rst_n=0, SHALL asynchronously set pos to LIMIT/2, truncated (540 with defaults), state to IDLE, latch empty, speed to SPEED_MIN, hold_cnt to 0, synchronisers to 0, at_min and at_max to 0.
REQ-029 Deassertion of rst_n mid-frame SHALL resume normal operation with no movement before the second subsequent fsync.

Structure
REQ-030 SHALL take the direction enum (IDLE, INC, DEC) and the 12-bit coordinate type from shared package paddle_pkg.
REQ-031 SHALL implement the synchroniser as sub-module btn_sync, one instance per button.

Verification
REQ-032 Scenario: defaults, release reset -> pos=540; active=1 at (540,700) and (739,719); active=0 at (740,700) and (540,699).
REQ-033 Scenario: hold inc from frame 0 -> pos unchanged at fsync 1; pos at fsync 2 through 9 SHALL read 541, 542, 543, 544, 546, 548, 550, 552.
REQ-034 Scenario: hold inc for 300 frames -> pos saturates at 1080 with at_max=1 and never exceeds 1080.
REQ-035 Scenario: inc and dec held together for 5 frames -> pos stays 540 and state stays IDLE.
REQ-036 Scenario: inc held until speed=3, then dec only -> the next move SHALL be DEC by 1 pixel, with speed reset to 1.
REQ-037 Scenario: rst_n pulsed low mid-frame while moving -> pos, speed and state SHALL return to reset values within the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/paddle_pkg.sv
// Shared types for the paddle mover.
//   coord_t      : signed 12-bit screen coordinate (scan position and paddle position)
//   dir_t        : paddle direction / latched request (IDLE, INC, DEC)
//   paddle_dbg_t : internal state exposed for observation
//   btn_request  : maps a pair of synchronised buttons onto a request
package paddle_pkg;

  typedef logic signed [11:0] coord_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INC  = 2'd1,
    DEC  = 2'd2
  } dir_t;

  typedef struct packed {
    dir_t       state;     // direction applied at the next fsync
    dir_t       req;       // request latched during the current frame
    logic [7:0] speed;     // step size for the next move
    logic [7:0] hold_cnt;  // moving frames since the last speed change
  } paddle_dbg_t;

  // Exactly one button pressed gives a request; both or neither give none.
  function automatic dir_t btn_request(input logic up, input logic down);
    if (up && !down) return INC;
    if (down && !up) return DEC;
    return IDLE;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for one asynchronous push button.
//   pixel_clk : destination clock
//   rst_n     : asynchronous active-low reset, clears both flops
//   btn       : raw asynchronous button level
//   btn_s     : button level synchronised to pixel_clk
module btn_sync (
  input  logic pixel_clk,
  input  logic rst_n,
  input  logic btn,
  output logic btn_s
);

  logic meta;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      meta  <= btn;
      btn_s <= meta;
    end
  end

endmodule

// File: rtl/paddle_mover.sv
// Paddle that moves along one screen axis under button control, accelerating
// while a direction is held, clamped to the screen, and drawn as a filled
// rectangle.
//   pixel_clk, rst_n : clock, asynchronous active-low reset
//   fsync            : one-cycle frame-start pulse; all movement happens here
//   hpos, vpos       : current scan coordinate (signed)
//   inc, dec         : asynchronous buttons toward higher / lower coordinates
//   pos              : leading coordinate of the paddle on the move axis
//   at_min, at_max   : paddle sits on a clamp limit
//   pixel[0:2]       : B, G, R bytes of the paddle colour while active
//   active           : scan position lies inside the paddle
//   dbg              : direction state, latched request, speed and hold count
module paddle_mover
  import paddle_pkg::*;
#(
  parameter int          HRES         = 1280,
  parameter int          VRES         = 720,
  parameter int          PADDLE_W     = 200,
  parameter int          PADDLE_H     = 20,
  parameter int          AXIS         = 0,
  parameter int          EDGE         = 700,
  parameter int          SPEED_MIN    = 1,
  parameter int          SPEED_MAX    = 8,
  parameter int          ACCEL_FRAMES = 4,
  parameter logic [23:0] COLOR        = 24'hEFE62E
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        fsync,
  input  coord_t      hpos,
  input  coord_t      vpos,
  input  logic        inc,
  input  logic        dec,
  output coord_t      pos,
  output logic        at_min,
  output logic        at_max,
  output logic [7:0]  pixel [0:2],
  output logic        active,
  output paddle_dbg_t dbg
);

  localparam int RES   = (AXIS == 0) ? HRES : VRES;
  localparam int LEN   = (AXIS == 0) ? PADDLE_W : PADDLE_H;
  localparam int CROSS = (AXIS == 0) ? PADDLE_H : PADDLE_W;
  localparam int LIMIT = RES - LEN;

  localparam coord_t     POS_RST = 12'(LIMIT / 2);
  localparam coord_t     POS_LIM = 12'(LIMIT);
  localparam logic [7:0] SPD_MIN = 8'(SPEED_MIN);
  localparam logic [7:0] SPD_MAX = 8'(SPEED_MAX);
  localparam logic [7:0] ACC_N   = 8'(ACCEL_FRAMES);

  logic inc_s, dec_s;

  btn_sync u_sync_inc (.pixel_clk(pixel_clk), .rst_n(rst_n), .btn(inc), .btn_s(inc_s));
  btn_sync u_sync_dec (.pixel_clk(pixel_clk), .rst_n(rst_n), .btn(dec), .btn_s(dec_s));

  dir_t       state, req, prev_dir;
  logic [7:0] speed, hold_cnt;

  // Next-move computation, consumed only on fsync.
  logic              reversal, restart;
  logic [7:0]        base_spd, base_hold, spd_nxt, hold_nxt;
  logic signed [12:0] pos_w, step_w, sum_w, lim_w;
  coord_t            pos_nxt;

  always_comb begin
    reversal  = ((state == INC) && (prev_dir == DEC)) ||
                ((state == DEC) && (prev_dir == INC));
    // Idle frames and direction reversals drop back to the slowest speed,
    // and a reversal makes its first move at that slow speed.
    restart   = (state == IDLE) || reversal;
    base_spd  = restart ? SPD_MIN : speed;
    base_hold = restart ? 8'd0 : hold_cnt;
    pos_w     = {pos[11], pos};
    step_w    = {5'd0, base_spd};
    lim_w     = 13'(LIMIT);
    sum_w     = pos_w;
    pos_nxt   = pos;
    spd_nxt   = base_spd;
    hold_nxt  = base_hold;
    case (state)
      INC: begin
        sum_w   = pos_w + step_w;
        pos_nxt = (sum_w > lim_w) ? POS_LIM : sum_w[11:0];
      end
      DEC: begin
        sum_w   = pos_w - step_w;
        pos_nxt = (sum_w < 0) ? 12'sd0 : sum_w[11:0];
      end
      default: ;
    endcase
    // The speed increment only affects moves after this one.
    if (state != IDLE) begin
      if (base_hold + 8'd1 == ACC_N) begin
        hold_nxt = 8'd0;
        spd_nxt  = (base_spd >= SPD_MAX) ? SPD_MAX : base_spd + 8'd1;
      end else begin
        hold_nxt = base_hold + 8'd1;
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      pos      <= POS_RST;
      state    <= IDLE;
      req      <= IDLE;
      prev_dir <= IDLE;
      speed    <= SPD_MIN;
      hold_cnt <= 8'd0;
      at_min   <= 1'b0;
      at_max   <= 1'b0;
    end else if (fsync) begin
      // Move with the direction loaded last frame, then load this frame's
      // request; a press therefore moves the paddle one frame later.
      pos      <= pos_nxt;
      at_min   <= (pos_nxt == 12'sd0);
      at_max   <= (pos_nxt == POS_LIM);
      speed    <= spd_nxt;
      hold_cnt <= hold_nxt;
      prev_dir <= state;
      state    <= req;
      req      <= IDLE;
    end else if (req == IDLE) begin
      // First unambiguous request of the frame wins and is held.
      req <= btn_request(inc_s, dec_s);
    end
  end

  // Rectangle hit test, inclusive bounds, done in int so nothing wraps.
  coord_t mv, cr;

  always_comb begin
    mv     = (AXIS == 0) ? hpos : vpos;
    cr     = (AXIS == 0) ? vpos : hpos;
    active = (mv >= 0) && (cr >= 0) &&
             (int'(mv) >= int'(pos)) && (int'(mv) <= int'(pos) + LEN - 1) &&
             (int'(cr) >= EDGE) && (int'(cr) <= EDGE + CROSS - 1);
    pixel[2] = active ? COLOR[23:16] : 8'd0;
    pixel[1] = active ? COLOR[15:8]  : 8'd0;
    pixel[0] = active ? COLOR[7:0]   : 8'd0;
  end

  always_comb begin
    dbg.state    = state;
    dbg.req      = req;
    dbg.speed    = speed;
    dbg.hold_cnt = hold_cnt;
  end

endmodule

// File: tb/tb_paddle_mover.sv
// Self-checking bench for paddle_mover with default parameters.
// A frame-level reference model tracks position, run length and speed;
// table vectors and hand-written sequences cover the fixed scenarios.
module tb_paddle_mover;
  import paddle_pkg::*;

  localparam int          HRES  = 1280;
  localparam int          VRES  = 720;
  localparam int          PW    = 200;
  localparam int          PH    = 20;
  localparam int          EDGE  = 700;
  localparam int          SMIN  = 1;
  localparam int          SMAX  = 8;
  localparam int          AF    = 4;
  localparam logic [23:0] COLOR = 24'hEFE62E;
  localparam int          LIMIT = HRES - PW;
  localparam int          POS0  = LIMIT / 2;

  // ---------------- clock / reset / DUT ----------------
  logic        pixel_clk = 1'b0;
  logic        rst_n     = 1'b0;
  logic        fsync     = 1'b0;
  logic        inc       = 1'b0;
  logic        dec       = 1'b0;
  coord_t      hpos      = 12'sd0;
  coord_t      vpos      = 12'sd0;
  coord_t      pos;
  logic        at_min, at_max, active;
  logic [7:0]  pixel [0:2];
  paddle_dbg_t dbg;

  paddle_mover #(
    .HRES(HRES), .VRES(VRES), .PADDLE_W(PW), .PADDLE_H(PH), .AXIS(0), .EDGE(EDGE),
    .SPEED_MIN(SMIN), .SPEED_MAX(SMAX), .ACCEL_FRAMES(AF), .COLOR(COLOR)
  ) dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .fsync(fsync), .hpos(hpos), .vpos(vpos),
    .inc(inc), .dec(dec), .pos(pos), .at_min(at_min), .at_max(at_max),
    .pixel(pixel), .active(active), .dbg(dbg)
  );

  always #5 pixel_clk = ~pixel_clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  int         m_pos, m_run, m_speed;
  dir_t       m_dir, m_run_dir;
  logic       m_at_min, m_at_max;
  logic [1:0] m_btn_prev, m_btn_cur;  // {inc,dec} of previous / current frame

  function automatic int speed_for(input int run);
    int s;
    s = SMIN + run / AF;
    return (s > SMAX) ? SMAX : s;
  endfunction

  // The synchroniser delay means the first cycles of a frame still see the
  // previous frame's buttons; the first unambiguous view wins.
  function automatic dir_t req_of(input logic [1:0] old_b, input logic [1:0] cur_b);
    if (old_b == 2'b10) return INC;
    if (old_b == 2'b01) return DEC;
    if (cur_b == 2'b10) return INC;
    if (cur_b == 2'b01) return DEC;
    return IDLE;
  endfunction

  function automatic logic ref_active(input int h, input int v, input int p);
    return (h >= 0) && (v >= 0) && (h >= p) && (h < p + PW) && (v >= EDGE) && (v < EDGE + PH);
  endfunction

  task automatic model_reset();
    m_pos = POS0; m_run = 0; m_speed = SMIN; m_dir = IDLE; m_run_dir = IDLE;
    m_at_min = 1'b0; m_at_max = 1'b0; m_btn_prev = 2'b00; m_btn_cur = 2'b00;
  endtask

  task automatic model_fsync();
    int spd;
    if (m_dir == IDLE) begin
      m_run = 0; m_run_dir = IDLE;
    end else begin
      if (m_dir != m_run_dir) m_run = 0;
      spd = speed_for(m_run);
      if (m_dir == INC) m_pos = (m_pos + spd > LIMIT) ? LIMIT : m_pos + spd;
      else              m_pos = (m_pos - spd < 0) ? 0 : m_pos - spd;
      m_run++;
      m_run_dir = m_dir;
    end
    m_speed  = speed_for(m_run);
    m_at_min = (m_pos == 0);
    m_at_max = (m_pos == LIMIT);
    m_dir    = req_of(m_btn_prev, m_btn_cur);
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst_n = 1'b0; fsync = 1'b0; inc = 1'b0; dec = 1'b0;
    repeat (2) @(posedge pixel_clk);
    #3 rst_n = 1'b1;
    @(posedge pixel_clk); #1;
    model_reset();
  endtask

  task automatic set_buttons(input logic bi, input logic bd);
    inc = bi; dec = bd; m_btn_cur = {bi, bd};
  endtask

  task automatic check_active(input string name, input int h, input int v, input logic exp_a);
    hpos = 12'(h); vpos = 12'(v); #1;
    check({name, ":active"}, active, exp_a);
    check({name, ":pixel"}, {pixel[2], pixel[1], pixel[0]}, exp_a ? COLOR : 24'd0);
  endtask

  task automatic check_regs(input string tag);
    check({tag, ":pos"}, pos, m_pos);
    check({tag, ":at_min"}, at_min, m_at_min);
    check({tag, ":at_max"}, at_max, m_at_max);
    check({tag, ":state"}, dbg.state, m_dir);
    check({tag, ":speed"}, dbg.speed, m_speed);
  endtask

  // Entered at 1 time unit after a rising edge: pulses fsync, checks the
  // frame update, applies next frame's buttons, runs len idle cycles.
  task automatic run_frame(input string tag, input logic bi, input logic bd, input int len);
    int h, v;
    fsync = 1'b1;
    @(posedge pixel_clk); #1;
    fsync = 1'b0;
    model_fsync();
    check_regs(tag);
    m_btn_prev = m_btn_cur;
    set_buttons(bi, bd);
    h = int'($urandom_range(0, 60)) - 30 + (($urandom_range(0, 1) == 1) ? m_pos : m_pos + PW - 1);
    v = EDGE - 3 + int'($urandom_range(0, PH + 5));
    if ($urandom_range(0, 15) == 0) h = -int'($urandom_range(1, 50));
    check_active({tag, ":rnd"}, h, v, ref_active(h, v, m_pos));
    repeat (len) @(posedge pixel_clk);
    #1;
  endtask

  // ---------------- vectors ----------------
  typedef struct { int h; int v; logic exp_a; } act_vec_t;
  act_vec_t vecs [12];

  initial begin
    int   prev_p;
    logic found;
    vecs[0]  = '{540, 700, 1'b1};  vecs[1]  = '{739, 719, 1'b1};
    vecs[2]  = '{740, 700, 1'b0};  vecs[3]  = '{540, 699, 1'b0};
    vecs[4]  = '{539, 710, 1'b0};  vecs[5]  = '{600, 720, 1'b0};
    vecs[6]  = '{640, 710, 1'b1};  vecs[7]  = '{-5, -5, 1'b0};
    vecs[8]  = '{0, 700, 1'b1};    vecs[9]  = '{-1, 700, 1'b0};
    vecs[10] = '{199, 719, 1'b1};  vecs[11] = '{200, 700, 1'b0};
    for (int i = 541; i <= 544; i++) exp_q.push_back(12'(i));
    for (int i = 546; i <= 552; i += 2) exp_q.push_back(12'(i));

    // Reset state and the hit test around the centred paddle.
    apply_reset();
    check("rst:pos", pos, POS0);
    check("rst:at_min", at_min, 0);
    check("rst:at_max", at_max, 0);
    check("rst:state", dbg.state, IDLE);
    check("rst:req", dbg.req, IDLE);
    check("rst:speed", dbg.speed, SMIN);
    check("rst:hold", dbg.hold_cnt, 0);
    for (int i = 0; i < 8; i++) check_active($sformatf("vec%0d", i), vecs[i].h, vecs[i].v, vecs[i].exp_a);

    // Hold inc from frame 0: no move at fsync 1, then accelerating steps.
    set_buttons(1'b1, 1'b0);
    repeat (5) @(posedge pixel_clk);
    #1;
    run_frame("inc_f1", 1'b1, 1'b0, 5);
    check("inc_f1:hold_pos", pos, 540);
    for (int f = 2; f <= 9; f++) begin
      run_frame($sformatf("inc_f%0d", f), 1'b1, 1'b0, 5);
      check($sformatf("inc_seq%0d", f), pos, exp_q.pop_front());
    end
    for (int f = 10; f <= 300; f++) begin
      run_frame("inc_long", 1'b1, 1'b0, 4);
      check("inc_long:le_limit", (pos <= LIMIT), 1);
    end
    check("sat:pos", pos, LIMIT);
    check("sat:at_max", at_max, 1);

    // Drive to the low clamp and test the hit test at the left edge.
    for (int f = 0; f < 170; f++) run_frame("dec_long", 1'b0, 1'b1, 4);
    check("floor:pos", pos, 0);
    check("floor:at_min", at_min, 1);
    check("floor:at_max", at_max, 0);
    for (int i = 8; i < 12; i++) check_active($sformatf("vec%0d", i), vecs[i].h, vecs[i].v, vecs[i].exp_a);

    // Both buttons held: no request, no movement.
    apply_reset();
    set_buttons(1'b1, 1'b1);
    repeat (5) @(posedge pixel_clk);
    #1;
    for (int f = 0; f < 5; f++) begin
      run_frame("both", 1'b1, 1'b1, 5);
      check("both:pos", pos, 540);
      check("both:state", dbg.state, IDLE);
    end

    // Accelerate to speed 3, then reverse: first reverse step is 1 pixel.
    apply_reset();
    set_buttons(1'b1, 1'b0);
    repeat (5) @(posedge pixel_clk);
    #1;
    found = 1'b0;
    for (int f = 0; f < 40 && !found; f++) begin
      run_frame("acc", 1'b1, 1'b0, 4);
      if (dbg.speed == 8'd3) found = 1'b1;
    end
    check("acc:reached_speed3", found, 1);
    found  = 1'b0;
    prev_p = pos;
    for (int f = 0; f < 6 && !found; f++) begin
      run_frame("rev", 1'b0, 1'b1, 4);
      if (pos < prev_p) begin
        found = 1'b1;
        check("rev:step", prev_p - pos, 1);
        check("rev:speed", dbg.speed, SMIN);
      end
      prev_p = pos;
    end
    check("rev:seen", found, 1);

    // Reset pulsed mid-frame while moving takes effect without a clock edge.
    apply_reset();
    set_buttons(1'b1, 1'b0);
    repeat (5) @(posedge pixel_clk);
    #1;
    for (int f = 0; f < 12; f++) run_frame("pre_rst", 1'b1, 1'b0, 6);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst:pos", pos, POS0);
    check("async_rst:state", dbg.state, IDLE);
    check("async_rst:speed", dbg.speed, SMIN);
    @(posedge pixel_clk);
    #3 rst_n = 1'b1;
    @(posedge pixel_clk); #1;
    model_reset();
    set_buttons(1'b1, 1'b0);
    repeat (4) @(posedge pixel_clk);
    #1;
    run_frame("post_rst1", 1'b1, 1'b0, 5);
    check("post_rst1:no_move", pos, POS0);
    run_frame("post_rst2", 1'b1, 1'b0, 5);
    check("post_rst2:first_move", pos, POS0 + 1);

    // Random buttons and frame lengths against the model.
    for (int f = 0; f < 250; f++) begin
      int r;
      logic bi, bd;
      r  = int'($urandom_range(0, 9));
      bi = (r <= 3) || (r == 7);
      bd = ((r >= 4) && (r <= 6)) || (r == 7);
      run_frame("rnd", bi, bd, int'($urandom_range(3, 10)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
